// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller: latches requests, masks, picks the lowest
// eligible index and runs the INT/ack/RETI handshake. Define IRQ_EDGE_EN for rising-edge sources.
module interrupt_controller #(
  parameter int          N_SRC      = 8,
  parameter int          ID_W       = 3,
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             int_ack,
  input  logic             reti,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic             INT,
  output logic [15:0]      vec,
  output logic [ID_W-1:0]  irq_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending,
  output logic [1:0]       state_dbg
);

  // Handshake: INT stays high in REQ until a one-cycle int_ack pulse; busy stays
  // high in SERVICE until a one-cycle reti pulse. Pulses in other states are ignored.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] set;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  sel_id;
  logic [15:0]      sel_vec;

  assign state_dbg = state;

`ifdef IRQ_EDGE_EN
  logic [N_SRC-1:0] irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq;
  end

  assign set = irq & ~irq_q;
`else
  assign set = irq;
`endif

  // Only the committed source is cleared, and only on the ack that ends REQ.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = (state == S_REQ) && int_ack && (irq_id == ID_W'(i));
    end
  end

  assign eligible = pending & ~mask;

  always_comb begin
    sel_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
  end

  assign sel_vec = VEC_BASE + VEC_STRIDE * 16'(sel_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= '0;
      pending <= '0;
    end else begin
      if (mask_we) mask <= mask_wdata;
      pending <= set | (pending & ~clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      INT    <= 1'b0;
      busy   <= 1'b0;
      vec    <= VEC_BASE;
      irq_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|eligible) begin
            irq_id <= sel_id;
            vec    <= sel_vec;
            INT    <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            INT   <= 1'b0;
            busy  <= 1'b1;
            state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          // No nesting: arbitration waits for reti plus one IDLE cycle.
          if (reti) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          INT   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vector table, level/edge hold sequence
// and randomized traffic against a behavioural model.
module tb_interrupt_controller;

  logic        clk;
  logic        rst;
  logic [7:0]  irq;
  logic        int_ack;
  logic        reti;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        int_line;
  logic [15:0] vec;
  logic [2:0]  irq_id;
  logic        busy;
  logic [7:0]  pending;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  interrupt_controller #(
    .N_SRC(8), .ID_W(3), .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq), .int_ack(int_ack), .reti(reti),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .INT(int_line), .vec(vec),
    .irq_id(irq_id), .busy(busy), .pending(pending), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // behavioural model: request outstanding / handler running as plain flags
  logic        m_req;
  logic        m_handler;
  logic [2:0]  m_id;
  logic [15:0] m_vec;
  logic [7:0]  m_pend;
  logic [7:0]  m_mask;
  logic [7:0]  m_prev;

  task automatic model_edge(input logic r, input logic [7:0] i_irq, input logic a,
                            input logic rt, input logic we, input logic [7:0] wd);
    logic [7:0] newly;
    logic [7:0] taken;
    logic [7:0] elig;
    if (r) begin
      m_req = 0; m_handler = 0; m_id = 0; m_vec = 16'h0100;
      m_pend = 0; m_mask = 0; m_prev = 0;
      return;
    end
`ifdef IRQ_EDGE_EN
    newly = i_irq & ~m_prev;
`else
    newly = i_irq;
`endif
    taken = (m_req && a) ? (8'd1 << m_id) : 8'd0;
    elig  = m_pend & ~m_mask;
    if (m_req) begin
      if (a) begin m_req = 0; m_handler = 1; end
    end else if (m_handler) begin
      if (rt) m_handler = 0;
    end else if (elig != 0) begin
      for (int k = 0; k < 8; k++) begin
        if (elig[k]) begin m_id = 3'(k); break; end
      end
      m_vec = 16'h0100 + 16'(m_id) * 16'h0010;
      m_req = 1;
    end
    m_pend = newly | (m_pend & ~taken);
    if (we) m_mask = wd;
    m_prev = i_irq;
  endtask

  // scoreboard
  task automatic check(input string name, input int tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", name, tag, got, exp);
    end
  endtask

  // driver: inputs at negedge, model and compare just after posedge
  task automatic step(input logic r, input logic [7:0] i_irq, input logic a,
                      input logic rt, input logic we, input logic [7:0] wd);
    @(negedge clk);
    rst = r; irq = i_irq; int_ack = a; reti = rt; mask_we = we; mask_wdata = wd;
    @(posedge clk);
    model_edge(r, i_irq, a, rt, we, wd);
    #1;
    cycle++;
    check("model", cycle, {3'b0, int_line, busy, irq_id, pending, vec},
          {3'b0, m_req, m_handler, m_id, m_pend, m_vec});
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        ack;
    logic        reti;
    logic        mwe;
    logic [7:0]  mdata;
    int          reps;
    logic        e_int;
    logic [2:0]  e_id;
    logic        e_busy;
    logic [7:0]  e_pend;
    logic [15:0] e_vec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(logic r, logic [7:0] i_irq, logic a, logic rt, logic we,
                               logic [7:0] wd, int reps, logic ei, logic [2:0] eid,
                               logic eb, logic [7:0] ep, logic [15:0] ev);
    vec_t v;
    v.rst = r; v.irq = i_irq; v.ack = a; v.reti = rt; v.mwe = we; v.mdata = wd;
    v.reps = reps; v.e_int = ei; v.e_id = eid; v.e_busy = eb; v.e_pend = ep; v.e_vec = ev;
    return v;
  endfunction

  initial begin
    int acks;
    rst = 1; irq = 0; int_ack = 0; reti = 0; mask_we = 0; mask_wdata = 0;

    // reset with all requests high
    tbl.push_back(row(1, 8'hFF, 0, 0, 0, 8'h00, 3, 0, 0, 0, 8'h00, 16'h0100));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 16'h0100));
    // priority: sources 2 and 5 together
    tbl.push_back(row(0, 8'h24, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h24, 16'h0100));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 2, 1, 2, 0, 8'h24, 16'h0120));
    tbl.push_back(row(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 2, 1, 8'h20, 16'h0120));
    tbl.push_back(row(0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 2, 0, 8'h20, 16'h0120));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 5, 0, 8'h20, 16'h0150));
    tbl.push_back(row(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 5, 1, 8'h00, 16'h0150));
    tbl.push_back(row(0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 5, 0, 8'h00, 16'h0150));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 5, 0, 8'h00, 16'h0150));
    // masked source stays pending, unmask releases it two cycles later
    tbl.push_back(row(0, 8'h04, 0, 0, 1, 8'h04, 1, 0, 5, 0, 8'h04, 16'h0150));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 2, 0, 5, 0, 8'h04, 16'h0150));
    tbl.push_back(row(0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 5, 0, 8'h04, 16'h0150));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 2, 0, 8'h04, 16'h0120));
    // mask writes in REQ do not withdraw; long wait for ack
    tbl.push_back(row(0, 8'h00, 0, 0, 1, 8'hFF, 1, 1, 2, 0, 8'h04, 16'h0120));
    tbl.push_back(row(0, 8'h00, 0, 0, 1, 8'h00, 1, 1, 2, 0, 8'h04, 16'h0120));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 10, 1, 2, 0, 8'h04, 16'h0120));
    // ack and reti together in REQ
    tbl.push_back(row(0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 2, 1, 8'h00, 16'h0120));
    tbl.push_back(row(0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 2, 0, 8'h00, 16'h0120));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 2, 0, 8'h00, 16'h0120));
    // reset while in SERVICE with another source pending
    tbl.push_back(row(0, 8'h01, 0, 0, 0, 8'h00, 1, 0, 2, 0, 8'h01, 16'h0120));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h01, 16'h0100));
    tbl.push_back(row(0, 8'h02, 1, 0, 0, 8'h00, 1, 0, 0, 1, 8'h02, 16'h0100));
    tbl.push_back(row(1, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 16'h0100));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 16'h0100));
    // ignored pulses: ack in IDLE/SERVICE, reti in IDLE/REQ
    tbl.push_back(row(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 16'h0100));
    tbl.push_back(row(0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 16'h0100));
    tbl.push_back(row(0, 8'h08, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h08, 16'h0100));
    tbl.push_back(row(0, 8'h00, 0, 1, 0, 8'h00, 2, 1, 3, 0, 8'h08, 16'h0130));
    tbl.push_back(row(0, 8'h00, 1, 0, 0, 8'h00, 2, 0, 3, 1, 8'h00, 16'h0130));
    tbl.push_back(row(0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 3, 0, 8'h00, 16'h0130));
    tbl.push_back(row(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 3, 0, 8'h00, 16'h0130));

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        step(tbl[r].rst, tbl[r].irq, tbl[r].ack, tbl[r].reti, tbl[r].mwe, tbl[r].mdata);
        check("int",     r, 32'(int_line), 32'(tbl[r].e_int));
        check("irq_id",  r, 32'(irq_id),   32'(tbl[r].e_id));
        check("busy",    r, 32'(busy),     32'(tbl[r].e_busy));
        check("pending", r, 32'(pending),  32'(tbl[r].e_pend));
        check("vec",     r, 32'(vec),      32'(tbl[r].e_vec));
      end
    end

    // irq[0] held high for 40 cycles, every request acked and returned
    step(1, 8'h00, 0, 0, 0, 8'h00);
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_req) acks++;
      step(0, 8'h01, m_req, m_handler, 0, 8'h00);
    end
    for (int k = 0; k < 8; k++) step(0, 8'h00, m_req, m_handler, 0, 8'h00);
`ifdef IRQ_EDGE_EN
    check("held_irq_services", 0, 32'(acks), 32'd1);
`else
    check("held_irq_repeat", 0, 32'(acks >= 10), 32'd1);
`endif

    // randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 199) == 0),
           8'($urandom & $urandom & $urandom),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0),
           8'($urandom & $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
